output_vc_controller_bank: RTL and testbench

- Parametrised per-output-port bank of output VC controllers, one lane per VC.
- Each lane keeps a credit counter and an output-VC availability flag.
- Sits after the crossbar output of the non-pipelined router. Feeds the VC allocator (availability) and the switch allocator (ready).
- Generalises the single-VC controller:
  - VC count is configurable.
  - Counters start full.
  - Increment and decrement saturate.
  - Credit-return latency is selectable.
  - Single-flit packets are handled.
  - Sticky protocol-error flags are provided.

---
 rtl/output_vc_controller_bank_if.sv | 46 ++++
 rtl/output_vc_controller_bank.sv | 118 +++++++++++
 tb/tb_output_vc_controller_bank.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/output_vc_controller_bank_if.sv
// Crossbar-side flit/credit/grant bundle and allocator-side status
// for one output port's bank of VC controllers.
interface output_vc_controller_bank_if #(
   parameter int DW = 32,
   parameter int VC_NUM = 4,
   parameter int BUF_DEPTH = 4
);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   logic                   valid;
   logic [DW-1:0]          data;
   logic [VC_NUM-1:0]      credit_upd;
   logic [VC_NUM-1:0]      outVCAvailableReset;
   logic [VC_NUM-1:0]      outVCAvailable;
   logic [VC_NUM-1:0]      outVCReady;
   logic [VC_NUM*CW-1:0]   credit_cnt;
   logic [VC_NUM-1:0]      err_overflow;
   logic [VC_NUM-1:0]      err_underflow;
   logic                   err_bad_vcid;

   modport master (
      output valid,
      output data,
      output credit_upd,
      output outVCAvailableReset,
      input  outVCAvailable,
      input  outVCReady,
      input  credit_cnt,
      input  err_overflow,
      input  err_underflow,
      input  err_bad_vcid
   );

   modport slave (
      input  valid,
      input  data,
      input  credit_upd,
      input  outVCAvailableReset,
      output outVCAvailable,
      output outVCReady,
      output credit_cnt,
      output err_overflow,
      output err_underflow,
      output err_bad_vcid
   );
endinterface

// File: rtl/output_vc_controller_bank.sv
// Per-output-port bank of VC controllers: saturating credit counters,
// availability flags and sticky protocol-error flags, one lane per VC.
module output_vc_controller_bank #(
   parameter int DW = 32,
   parameter int VC_NUM = 4,
   parameter int BUF_DEPTH = 4,
   parameter int CREDIT_LBOUND = 0,
   parameter int CREDIT_DELAY = 1,
   parameter logic [1:0] TAIL_CODE = 2'b10,
   parameter logic [1:0] SINGLE_CODE = 2'b11
) (
   input logic clk,
   input logic rstn,
   output_vc_controller_bank_if.slave bus
);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
   localparam logic [CW-1:0] ONE = CW'(1);

   logic [1:0] vcid;
   logic [1:0] ftype;
   logic       vc_ok;
   logic       is_last;
   logic       unused_payload;

   logic [VC_NUM-1:0]         send;
   logic [VC_NUM-1:0]         cred;
   logic [VC_NUM-1:0]         ready;
   logic [VC_NUM-1:0][CW-1:0] cnt_d, cnt_q;
   logic [VC_NUM-1:0]         avail_d, avail_q;
   logic [VC_NUM-1:0]         ovf_d, ovf_q;
   logic [VC_NUM-1:0]         unf_d, unf_q;
   logic                      bad_d, bad_q;

   assign vcid    = bus.data[DW-1:DW-2];
   assign ftype   = bus.data[DW-3:DW-4];
   assign vc_ok   = int'(vcid) < VC_NUM;
   assign is_last = (ftype == TAIL_CODE) || (ftype == SINGLE_CODE);
   assign unused_payload = ^bus.data[DW-5:0];

   generate
      if (CREDIT_DELAY == 0) begin : g_direct
         assign cred = bus.credit_upd;
      end else begin : g_delay
         // One-cycle return path models the wire delay back from downstream
         logic [VC_NUM-1:0] cu_d, cu_q;
         assign cu_d = bus.credit_upd;
         always_ff @(posedge clk) begin
            if (!rstn) cu_q <= '0;
            else       cu_q <= cu_d;
         end
         assign cred = cu_q;
      end
   endgenerate

   always_comb begin
      send = '0;
      for (int i = 0; i < VC_NUM; i++)
         send[i] = bus.valid && (int'(vcid) == i);
   end

   always_comb begin
      cnt_d   = cnt_q;
      avail_d = avail_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      bad_d   = bad_q | (bus.valid & ~vc_ok);
      for (int i = 0; i < VC_NUM; i++) begin
         // A send and a credit in the same cycle cancel out
         unique case (1'b1)
            send[i] && !cred[i]: begin
               if (cnt_q[i] == '0) unf_d[i] = 1'b1;
               else                cnt_d[i] = cnt_q[i] - ONE;
            end
            cred[i] && !send[i]: begin
               if (cnt_q[i] == FULL) ovf_d[i] = 1'b1;
               else                  cnt_d[i] = cnt_q[i] + ONE;
            end
            default: ;
         endcase
         // Grant beats a departing tail so the VC can be reclaimed at once
         if (bus.outVCAvailableReset[i])
            avail_d[i] = 1'b0;
         else if (send[i] && is_last)
            avail_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < VC_NUM; i++)
            cnt_q[i] <= FULL;
         avail_q <= '1;
         ovf_q   <= '0;
         unf_q   <= '0;
         bad_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         avail_q <= avail_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         bad_q   <= bad_d;
      end
   end

   always_comb begin
      ready = '0;
      for (int i = 0; i < VC_NUM; i++)
         ready[i] = int'(cnt_q[i]) > CREDIT_LBOUND;
   end

   assign bus.credit_cnt     = cnt_q;
   assign bus.outVCAvailable = avail_q;
   assign bus.outVCReady     = ready;
   assign bus.err_overflow   = ovf_q;
   assign bus.err_underflow  = unf_q;
   assign bus.err_bad_vcid   = bad_q;
endmodule

// File: tb/tb_output_vc_controller_bank.sv
// Bench for output_vc_controller_bank: vector table with scoreboard on the
// default bank, plus short sequences for zero-delay credits and VC_NUM=2.
module tb_output_vc_controller_bank;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   output_vc_controller_bank_if #(.DW(32), .VC_NUM(4), .BUF_DEPTH(4)) m ();
   output_vc_controller_bank_if #(.DW(32), .VC_NUM(4), .BUF_DEPTH(4)) d ();
   output_vc_controller_bank_if #(.DW(32), .VC_NUM(2), .BUF_DEPTH(4)) n ();

   output_vc_controller_bank #(
      .DW(32), .VC_NUM(4), .BUF_DEPTH(4), .CREDIT_LBOUND(0), .CREDIT_DELAY(1),
      .TAIL_CODE(2'b10), .SINGLE_CODE(2'b11)
   ) u_main (.clk(clk), .rstn(rstn), .bus(m.slave));

   output_vc_controller_bank #(
      .DW(32), .VC_NUM(4), .BUF_DEPTH(4), .CREDIT_LBOUND(0), .CREDIT_DELAY(0),
      .TAIL_CODE(2'b10), .SINGLE_CODE(2'b11)
   ) u_d0 (.clk(clk), .rstn(rstn), .bus(d.slave));

   output_vc_controller_bank #(
      .DW(32), .VC_NUM(2), .BUF_DEPTH(4), .CREDIT_LBOUND(0), .CREDIT_DELAY(1),
      .TAIL_CODE(2'b10), .SINGLE_CODE(2'b11)
   ) u_n2 (.clk(clk), .rstn(rstn), .bus(n.slave));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit       rst;
      bit       v;
      bit [1:0] vc;
      bit [1:0] ft;
      bit [3:0] cu;
      bit [3:0] gr;
      int       c0, c1, c2, c3;
      bit [3:0] av, rdy, ovf, unf;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [11:0] pk(int c0, int c1, int c2, int c3);
      return {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
   endfunction

   function automatic vec_t mk(bit rst, bit v, bit [1:0] vc, bit [1:0] ft,
                               bit [3:0] cu, bit [3:0] gr,
                               int c0, int c1, int c2, int c3,
                               bit [3:0] av, bit [3:0] rdy,
                               bit [3:0] ovf, bit [3:0] unf);
      vec_t r;
      r.rst = rst; r.v = v; r.vc = vc; r.ft = ft; r.cu = cu; r.gr = gr;
      r.c0 = c0; r.c1 = c1; r.c2 = c2; r.c3 = c3;
      r.av = av; r.rdy = rdy; r.ovf = ovf; r.unf = unf;
      return r;
   endfunction

   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      rstn = !v.rst;
      m.valid = v.v;
      m.data = {v.vc, v.ft, 28'($urandom)};
      m.credit_upd = v.cu;
      m.outVCAvailableReset = v.gr;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("r%0d cnt", idx), 32'(m.credit_cnt),
          32'(pk(e.c0, e.c1, e.c2, e.c3)));
      chk($sformatf("r%0d avail", idx), 32'(m.outVCAvailable), 32'(e.av));
      chk($sformatf("r%0d ready", idx), 32'(m.outVCReady), 32'(e.rdy));
      chk($sformatf("r%0d ovf", idx), 32'(m.err_overflow), 32'(e.ovf));
      chk($sformatf("r%0d unf", idx), 32'(m.err_underflow), 32'(e.unf));
      chk($sformatf("r%0d badvc", idx), 32'(m.err_bad_vcid), 32'd0);
   endtask

   task automatic cyc_d(bit r, bit v, bit [1:0] vc, bit [3:0] cu);
      @(negedge clk);
      rstn = !r;
      d.valid = v;
      d.data = {vc, 2'b01, 28'($urandom)};
      d.credit_upd = cu;
      d.outVCAvailableReset = '0;
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_n(bit r, bit v, bit [1:0] vc, bit [1:0] ft);
      @(negedge clk);
      rstn = !r;
      n.valid = v;
      n.data = {vc, ft, 28'($urandom)};
      n.credit_upd = '0;
      n.outVCAvailableReset = '0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      m.valid = 0; m.data = '0; m.credit_upd = '0; m.outVCAvailableReset = '0;
      d.valid = 0; d.data = '0; d.credit_upd = '0; d.outVCAvailableReset = '0;
      n.valid = 0; n.data = '0; n.credit_upd = '0; n.outVCAvailableReset = '0;

      //            rst v vc ft cu gr   c0 c1 c2 c3  av    rdy   ovf   unf
      tbl.push_back(mk(1,0,0,0,0,0, 4,4,4,4, 4'hF,4'hF,4'h0,4'h0));
      tbl.push_back(mk(0,1,2,0,0,0, 4,4,3,4, 4'hF,4'hF,4'h0,4'h0));
      tbl.push_back(mk(0,1,2,1,0,0, 4,4,2,4, 4'hF,4'hF,4'h0,4'h0));
      tbl.push_back(mk(0,1,2,1,0,0, 4,4,1,4, 4'hF,4'hF,4'h0,4'h0));
      tbl.push_back(mk(0,1,2,1,0,0, 4,4,0,4, 4'hF,4'hB,4'h0,4'h0));
      tbl.push_back(mk(0,1,1,0,0,0, 4,3,0,4, 4'hF,4'hB,4'h0,4'h0));
      tbl.push_back(mk(0,1,1,1,0,0, 4,2,0,4, 4'hF,4'hB,4'h0,4'h0));
      tbl.push_back(mk(0,0,0,0,2,0, 4,2,0,4, 4'hF,4'hB,4'h0,4'h0));
      tbl.push_back(mk(0,0,0,0,0,0, 4,3,0,4, 4'hF,4'hB,4'h0,4'h0));
      tbl.push_back(mk(0,1,0,0,0,0, 3,3,0,4, 4'hF,4'hB,4'h0,4'h0));
      tbl.push_back(mk(0,1,0,1,0,0, 2,3,0,4, 4'hF,4'hB,4'h0,4'h0));
      tbl.push_back(mk(0,1,0,1,0,0, 1,3,0,4, 4'hF,4'hB,4'h0,4'h0));
      tbl.push_back(mk(0,1,0,1,0,0, 0,3,0,4, 4'hF,4'hA,4'h0,4'h0));
      tbl.push_back(mk(0,0,0,0,1,0, 0,3,0,4, 4'hF,4'hA,4'h0,4'h0));
      tbl.push_back(mk(0,1,0,1,0,0, 0,3,0,4, 4'hF,4'hA,4'h0,4'h0));
      tbl.push_back(mk(0,1,0,1,0,0, 0,3,0,4, 4'hF,4'hA,4'h0,4'h1));
      tbl.push_back(mk(0,0,0,0,1,0, 0,3,0,4, 4'hF,4'hA,4'h0,4'h1));
      tbl.push_back(mk(0,0,0,0,1,0, 1,3,0,4, 4'hF,4'hB,4'h0,4'h1));
      tbl.push_back(mk(0,0,0,0,1,0, 2,3,0,4, 4'hF,4'hB,4'h0,4'h1));
      tbl.push_back(mk(0,0,0,0,1,0, 3,3,0,4, 4'hF,4'hB,4'h0,4'h1));
      tbl.push_back(mk(0,0,0,0,1,0, 4,3,0,4, 4'hF,4'hB,4'h0,4'h1));
      tbl.push_back(mk(0,0,0,0,0,0, 4,3,0,4, 4'hF,4'hB,4'h1,4'h1));
      tbl.push_back(mk(0,0,0,0,0,8, 4,3,0,4, 4'h7,4'hB,4'h1,4'h1));
      tbl.push_back(mk(0,1,3,1,0,0, 4,3,0,3, 4'h7,4'hB,4'h1,4'h1));
      tbl.push_back(mk(0,1,3,2,0,0, 4,3,0,2, 4'hF,4'hB,4'h1,4'h1));
      tbl.push_back(mk(0,0,0,0,0,8, 4,3,0,2, 4'h7,4'hB,4'h1,4'h1));
      tbl.push_back(mk(0,1,3,3,0,0, 4,3,0,1, 4'hF,4'hB,4'h1,4'h1));
      tbl.push_back(mk(0,1,3,2,0,8, 4,3,0,0, 4'h7,4'h3,4'h1,4'h1));
      tbl.push_back(mk(0,0,0,0,0,8, 4,3,0,0, 4'h7,4'h3,4'h1,4'h1));
      tbl.push_back(mk(0,0,0,0,0,2, 4,3,0,0, 4'h5,4'h3,4'h1,4'h1));
      tbl.push_back(mk(0,1,1,1,0,0, 4,2,0,0, 4'h5,4'h3,4'h1,4'h1));
      tbl.push_back(mk(0,1,1,1,0,0, 4,1,0,0, 4'h5,4'h3,4'h1,4'h1));
      tbl.push_back(mk(1,1,1,1,2,0, 4,4,4,4, 4'hF,4'hF,4'h0,4'h0));
      tbl.push_back(mk(0,0,0,0,0,0, 4,4,4,4, 4'hF,4'hF,4'h0,4'h0));
      tbl.push_back(mk(0,1,2,2,0,1, 4,4,3,4, 4'hE,4'hF,4'h0,4'h0));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], i);
      @(negedge clk);
      m.valid = 0; m.credit_upd = '0; m.outVCAvailableReset = '0;

      // Zero-delay credit return
      cyc_d(1, 0, 0, 4'b0000);
      chk("d0 reset cnt", 32'(d.credit_cnt), 32'(pk(4, 4, 4, 4)));
      cyc_d(0, 1, 1, 4'b0000);
      cyc_d(0, 1, 1, 4'b0000);
      chk("d0 c1 two sends", 32'(d.credit_cnt), 32'(pk(4, 2, 4, 4)));
      cyc_d(0, 0, 0, 4'b0010);
      chk("d0 credit at T+1", 32'(d.credit_cnt), 32'(pk(4, 3, 4, 4)));
      cyc_d(0, 1, 1, 4'b0010);
      chk("d0 send+credit hold", 32'(d.credit_cnt), 32'(pk(4, 3, 4, 4)));
      chk("d0 no err", 32'({d.err_overflow, d.err_underflow}), 32'd0);
      cyc_d(0, 0, 0, 4'b0001);
      chk("d0 full credit cnt", 32'(d.credit_cnt), 32'(pk(4, 3, 4, 4)));
      chk("d0 full credit ovf", 32'(d.err_overflow), 32'h1);
      @(negedge clk);
      d.valid = 0; d.credit_upd = '0;

      // Out-of-range VC id on a two-VC bank
      cyc_n(1, 0, 0, 2'b00);
      chk("n2 reset cnt", 32'(n.credit_cnt), 32'({3'd4, 3'd4}));
      cyc_n(0, 0, 3, 2'b00);
      chk("n2 idle vcid3 no err", 32'(n.err_bad_vcid), 32'd0);
      cyc_n(0, 1, 3, 2'b10);
      chk("n2 bad vcid flag", 32'(n.err_bad_vcid), 32'd1);
      chk("n2 bad vcid cnt", 32'(n.credit_cnt), 32'({3'd4, 3'd4}));
      chk("n2 bad vcid avail", 32'(n.outVCAvailable), 32'h3);
      cyc_n(0, 1, 1, 2'b01);
      chk("n2 vc1 send cnt", 32'(n.credit_cnt), 32'({3'd3, 3'd4}));
      chk("n2 bad vcid sticky", 32'(n.err_bad_vcid), 32'd1);
      cyc_n(1, 0, 0, 2'b00);
      chk("n2 reset clears", 32'(n.err_bad_vcid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
